mips_dual_port_memory: RTL and testbench

//  Parametrised unified instruction/data memory for the MIPS core. One read-only instruction port and one read/write data port,

---
 rtl/mips_dual_port_memory_pkg.sv | 23 ++
 rtl/mips_dual_port_memory_if.sv | 36 +++
 rtl/mips_dual_port_memory_be_merge.sv | 20 ++
 rtl/mips_dual_port_memory.sv | 157 +++++++++++++++
 tb/tb_mips_dual_port_memory.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_dual_port_memory_pkg.sv
// Shared types and address helpers for the unified MIPS instruction/data memory.
package mips_mem_pkg;

  typedef enum logic {
    INIT,
    RUN
  } mem_state_t;

  localparam int BYTE_W     = 8;
  localparam int MAX_ADDR_W = 64;

  // Byte address to word index; depth is a power of two so masking wraps the index.
  function automatic logic [MAX_ADDR_W-1:0] word_idx(input logic [MAX_ADDR_W-1:0] addr,
                                                     input int unsigned depth);
    return (addr >> 2) & (MAX_ADDR_W'(depth) - MAX_ADDR_W'(1));
  endfunction

  function automatic logic in_range(input logic [MAX_ADDR_W-1:0] addr,
                                    input int unsigned depth);
    return addr < (MAX_ADDR_W'(depth) << 2);
  endfunction

endpackage

// File: rtl/mips_dual_port_memory_if.sv
// Request/response bundle for the instruction (read-only) and data (read/write) memory ports.
interface mips_dual_port_memory_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic                  i_req_valid;
  logic                  i_req_ready;
  logic [ADDR_W-1:0]     i_req_addr;
  logic                  i_rsp_valid;
  logic [DATA_W-1:0]     i_rsp_data;
  logic                  i_rsp_err;

  logic                  d_req_valid;
  logic                  d_req_ready;
  logic                  d_req_write;
  logic [ADDR_W-1:0]     d_req_addr;
  logic [DATA_W-1:0]     d_req_wdata;
  logic [DATA_W/8-1:0]   d_req_be;
  logic                  d_rsp_valid;
  logic [DATA_W-1:0]     d_rsp_rdata;
  logic                  d_rsp_err;

  modport master (
    output i_req_valid, i_req_addr,
    input  i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
    output d_req_valid, d_req_write, d_req_addr, d_req_wdata, d_req_be,
    input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
  );

  modport slave (
    input  i_req_valid, i_req_addr,
    output i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
    input  d_req_valid, d_req_write, d_req_addr, d_req_wdata, d_req_be,
    output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
  );
endinterface

// File: rtl/mips_dual_port_memory_be_merge.sv
// Byte-enable merge: replaces the enabled bytes of the old word with write data.
module mips_mem_be_merge
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0]        old_word,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/BYTE_W-1:0] be,
  output logic [DATA_W-1:0]        merged
);

  always_comb begin
    merged = old_word;
    for (int k = 0; k < int'(DATA_W / BYTE_W); k++) begin
      if (be[k]) merged[k*BYTE_W +: BYTE_W] = wdata[k*BYTE_W +: BYTE_W];
    end
  end

endmodule

// File: rtl/mips_dual_port_memory.sv
// Unified instruction/data memory with self-clearing init and registered responses.
// Define MIPS_MEM_OUT_REG_EN to add a second response register (2-cycle latency).
//
// state | meaning
// INIT  | zeroing one word per cycle, both ports not ready
// RUN   | both ports ready, init_done high until next reset
module mips_dual_port_memory
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_W     = 32,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic                   MIPS_memory_clk,
  input  logic                   MIPS_memory_rst_n,
  output logic                   MIPS_init_done,
  mips_dual_port_memory_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  mem_state_t        state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              clr_en;
  logic              run;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge MIPS_memory_clk or negedge MIPS_memory_rst_n) begin
    if (!MIPS_memory_rst_n) begin
      state_q <= INIT_CLEAR ? INIT : RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_en  = 1'b0;
    run     = 1'b0;
    case (state_q)
      INIT: begin
        clr_en = 1'b1;
        cnt_d  = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(DEPTH - 1)) state_d = RUN;
      end
      RUN: run = 1'b1;
      default: state_d = INIT;
    endcase
  end

  assign bus.i_req_ready = run;
  assign bus.d_req_ready = run;
  assign MIPS_init_done  = run;

  logic [IDX_W-1:0]  i_idx, d_idx;
  logic              i_err, d_err;
  logic              i_acc, d_acc, d_wr_en, bypass;
  logic [DATA_W-1:0] d_old, d_merged, i_word, d_word;

  assign i_idx   = IDX_W'(word_idx(MAX_ADDR_W'(bus.i_req_addr), DEPTH));
  assign d_idx   = IDX_W'(word_idx(MAX_ADDR_W'(bus.d_req_addr), DEPTH));
  assign i_err   = !in_range(MAX_ADDR_W'(bus.i_req_addr), DEPTH);
  assign d_err   = !in_range(MAX_ADDR_W'(bus.d_req_addr), DEPTH) || (bus.d_req_addr[1:0] != 2'b00);
  assign i_acc   = bus.i_req_valid && run;
  assign d_acc   = bus.d_req_valid && run;
  assign d_wr_en = d_acc && bus.d_req_write && !d_err;
  assign d_old   = mem[d_idx];

  mips_mem_be_merge #(.DATA_W(DATA_W)) u_be_merge (
    .old_word (d_old),
    .wdata    (bus.d_req_wdata),
    .be       (bus.d_req_be),
    .merged   (d_merged)
  );

  // Write-first: an instruction read hitting the word being written sees the merged value.
  assign bypass = i_acc && !i_err && d_wr_en && (i_idx == d_idx);
  assign i_word = i_err ? '0 : (bypass ? d_merged : mem[i_idx]);
  assign d_word = (d_err || bus.d_req_write) ? '0 : d_old;

  always_ff @(posedge MIPS_memory_clk) begin
    if (clr_en) mem[cnt_q] <= '0;
    else if (d_wr_en) mem[d_idx] <= d_merged;
  end

  logic              i_v1, i_e1, d_v1, d_e1;
  logic [DATA_W-1:0] i_d1, d_d1;

  always_ff @(posedge MIPS_memory_clk or negedge MIPS_memory_rst_n) begin
    if (!MIPS_memory_rst_n) begin
      i_v1 <= 1'b0;
      i_d1 <= '0;
      i_e1 <= 1'b0;
      d_v1 <= 1'b0;
      d_d1 <= '0;
      d_e1 <= 1'b0;
    end else begin
      i_v1 <= i_acc;
      d_v1 <= d_acc;
      if (i_acc) begin
        i_d1 <= i_word;
        i_e1 <= i_err;
      end
      if (d_acc) begin
        d_d1 <= d_word;
        d_e1 <= d_err;
      end
    end
  end

`ifdef MIPS_MEM_OUT_REG_EN
  logic              i_v2, i_e2, d_v2, d_e2;
  logic [DATA_W-1:0] i_d2, d_d2;

  always_ff @(posedge MIPS_memory_clk or negedge MIPS_memory_rst_n) begin
    if (!MIPS_memory_rst_n) begin
      i_v2 <= 1'b0;
      i_d2 <= '0;
      i_e2 <= 1'b0;
      d_v2 <= 1'b0;
      d_d2 <= '0;
      d_e2 <= 1'b0;
    end else begin
      i_v2 <= i_v1;
      d_v2 <= d_v1;
      if (i_v1) begin
        i_d2 <= i_d1;
        i_e2 <= i_e1;
      end
      if (d_v1) begin
        d_d2 <= d_d1;
        d_e2 <= d_e1;
      end
    end
  end

  assign bus.i_rsp_valid = i_v2;
  assign bus.i_rsp_data  = i_d2;
  assign bus.i_rsp_err   = i_e2;
  assign bus.d_rsp_valid = d_v2;
  assign bus.d_rsp_rdata = d_d2;
  assign bus.d_rsp_err   = d_e2;
`else
  assign bus.i_rsp_valid = i_v1;
  assign bus.i_rsp_data  = i_d1;
  assign bus.i_rsp_err   = i_e1;
  assign bus.d_rsp_valid = d_v1;
  assign bus.d_rsp_rdata = d_d1;
  assign bus.d_rsp_err   = d_e1;
`endif

endmodule

// File: tb/tb_mips_dual_port_memory.sv
// Directed vector bench for mips_dual_port_memory (DEPTH=256, 32-bit words).
module tb_mips_dual_port_memory;

`ifdef MIPS_MEM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic init_done;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mips_dual_port_memory_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  mips_dual_port_memory #(
    .DATA_W(32), .DEPTH(256), .ADDR_W(32), .INIT_CLEAR(1'b1)
  ) dut (
    .MIPS_memory_clk   (clk),
    .MIPS_memory_rst_n (rst_n),
    .MIPS_init_done    (init_done),
    .bus               (bus)
  );

  typedef struct {
    string       name;
    bit          iv;
    logic [31:0] ia;
    bit          dv;
    bit          dw;
    logic [31:0] da;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] exp_id;
    bit          exp_ie;
    logic [31:0] exp_dd;
    bit          exp_de;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_req_valid = 1'b0;
    bus.i_req_addr  = '0;
    bus.d_req_valid = 1'b0;
    bus.d_req_write = 1'b0;
    bus.d_req_addr  = '0;
    bus.d_req_wdata = '0;
    bus.d_req_be    = '0;
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    check({tag, "_done_low"}, 32'(init_done), 32'd0);
    while (!bus.i_req_ready && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_init_cycles"}, n, 32'd256);
    check({tag, "_d_ready"}, 32'(bus.d_req_ready), 32'd1);
    check({tag, "_init_done"}, 32'(init_done), 32'd1);
  endtask

  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    bus.i_req_valid = v.iv;
    bus.i_req_addr  = v.ia;
    bus.d_req_valid = v.dv;
    bus.d_req_write = v.dw;
    bus.d_req_addr  = v.da;
    bus.d_req_wdata = v.wd;
    bus.d_req_be    = v.be;
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b0;
    bus.d_req_valid = 1'b0;
    repeat (LAT - 1) begin
      @(posedge clk);
      #1;
    end
    check({v.name, "_i_valid"}, 32'(bus.i_rsp_valid), 32'(v.iv));
    check({v.name, "_d_valid"}, 32'(bus.d_rsp_valid), 32'(v.dv));
    if (v.iv) begin
      check({v.name, "_i_data"}, bus.i_rsp_data, v.exp_id);
      check({v.name, "_i_err"}, 32'(bus.i_rsp_err), 32'(v.exp_ie));
    end
    if (v.dv) begin
      check({v.name, "_d_data"}, bus.d_rsp_rdata, v.exp_dd);
      check({v.name, "_d_err"}, 32'(bus.d_rsp_err), 32'(v.exp_de));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t rd10;
    //          name         iv ia      dv dw da      wd            be     exp_id        ie exp_dd        de
    vecs[0]  = '{"w10",       0, 32'h0,   1, 1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        0, 32'h0,        0};
    vecs[1]  = '{"r10",       0, 32'h0,   1, 0, 32'h10,  32'h0,        4'h0, 32'h0,        0, 32'hDEADBEEF, 0};
    vecs[2]  = '{"w10_be1",   0, 32'h0,   1, 1, 32'h10,  32'h000000AA, 4'h1, 32'h0,        0, 32'h0,        0};
    vecs[3]  = '{"r10_merge", 0, 32'h0,   1, 0, 32'h10,  32'h0,        4'h0, 32'h0,        0, 32'hDEADBEAA, 0};
    vecs[4]  = '{"i_r10",     1, 32'h10,  0, 0, 32'h0,   32'h0,        4'h0, 32'hDEADBEAA, 0, 32'h0,        0};
    vecs[5]  = '{"coll",      1, 32'h20,  1, 1, 32'h20,  32'h12345678, 4'hF, 32'h12345678, 0, 32'h0,        0};
    vecs[6]  = '{"r20",       0, 32'h0,   1, 0, 32'h20,  32'h0,        4'h0, 32'h0,        0, 32'h12345678, 0};
    vecs[7]  = '{"err_rd",    1, 32'h400, 1, 0, 32'h402, 32'h0,        4'h0, 32'h0,        1, 32'h0,        1};
    vecs[8]  = '{"err_wr",    1, 32'h24,  1, 1, 32'h26,  32'hFFFFFFFF, 4'hF, 32'h0,        0, 32'h0,        1};
    vecs[9]  = '{"r24",       1, 32'h3FF, 1, 0, 32'h24,  32'h0,        4'h0, 32'h0,        0, 32'h0,        0};
    vecs[10] = '{"be0",       0, 32'h0,   1, 1, 32'h20,  32'h0,        4'h0, 32'h0,        0, 32'h0,        0};
    vecs[11] = '{"r20_be0",   1, 32'h20,  1, 0, 32'h20,  32'h0,        4'h0, 32'h12345678, 0, 32'h12345678, 0};
    vecs[12] = '{"oob_wr",    1, 32'h3FC, 1, 1, 32'h400, 32'h11111111, 4'hF, 32'h0,        0, 32'h0,        1};
    vecs[13] = '{"r0",        1, 32'h0,   1, 0, 32'h0,   32'h0,        4'h0, 32'h0,        0, 32'h0,        0};
    vecs[14] = '{"be_mid",    0, 32'h0,   1, 1, 32'h30,  32'hA1B2C3D4, 4'h6, 32'h0,        0, 32'h0,        0};
    vecs[15] = '{"r30",       1, 32'h30,  1, 0, 32'h30,  32'h0,        4'h0, 32'h00B2C300, 0, 32'h00B2C300, 0};
    vecs[16] = '{"coll_be",   1, 32'h32,  1, 1, 32'h30,  32'hFFFFFFFF, 4'h8, 32'hFFB2C300, 0, 32'h0,        0};
    vecs[17] = '{"r30b",      1, 32'h30,  1, 0, 32'h3FC, 32'h0,        4'h0, 32'hFFB2C300, 0, 32'h0,        0};

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_i_ready", 32'(bus.i_req_ready), 32'd0);
    check("rst_i_valid", 32'(bus.i_rsp_valid), 32'd0);
    check("rst_d_valid", 32'(bus.d_rsp_valid), 32'd0);
    check("rst_d_data", bus.d_rsp_rdata, 32'd0);
    rst_n = 1'b1;
    wait_init("por");

    for (int i = 0; i < 18; i++) apply_vec(vecs[i]);

    // Back-to-back write then read of the same word, then idle hold.
    @(negedge clk);
    bus.d_req_valid = 1'b1;
    bus.d_req_write = 1'b1;
    bus.d_req_addr  = 32'h40;
    bus.d_req_wdata = 32'hCAFEF00D;
    bus.d_req_be    = 4'hF;
    for (int c = 0; c < LAT + 2; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) bus.d_req_write = 1'b0;
      else if (c == 1) bus.d_req_valid = 1'b0;
      if (c == LAT - 1) begin
        check("b2b_wr_valid", 32'(bus.d_rsp_valid), 32'd1);
        check("b2b_wr_data", bus.d_rsp_rdata, 32'd0);
      end
      if (c == LAT) begin
        check("b2b_rd_valid", 32'(bus.d_rsp_valid), 32'd1);
        check("b2b_rd_data", bus.d_rsp_rdata, 32'hCAFEF00D);
      end
      if (c == LAT + 1) begin
        check("idle_valid", 32'(bus.d_rsp_valid), 32'd0);
        check("idle_hold", bus.d_rsp_rdata, 32'hCAFEF00D);
      end
    end

    // Reset mid-stream with both ports responding.
    @(negedge clk);
    bus.i_req_valid = 1'b1;
    bus.i_req_addr  = 32'h10;
    bus.d_req_valid = 1'b1;
    bus.d_req_addr  = 32'h40;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    idle_inputs();
    check("mid_rst_i_valid", 32'(bus.i_rsp_valid), 32'd0);
    check("mid_rst_d_valid", 32'(bus.d_rsp_valid), 32'd0);
    check("mid_rst_i_data", bus.i_rsp_data, 32'd0);
    check("mid_rst_d_data", bus.d_rsp_rdata, 32'd0);
    check("mid_rst_ready", 32'(bus.d_req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_init("rerun");

    rd10 = '{"recleared", 1, 32'h40, 1, 0, 32'h10, 32'h0, 4'h0, 32'h0, 0, 32'h0, 0};
    apply_vec(rd10);
    apply_vec(vecs[0]);
    apply_vec(vecs[1]);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
